// File: rtl/aqfp_pla_pipe_if.sv
// aqfp_pla_pipe_if: config, input and result handshake bundle for the PLA pipeline
interface aqfp_pla_pipe_if #(
    parameter int NUM_IN = 26,
    parameter int NUM_OUT = 10,
    parameter int AW = 5
);
    logic cfg_we;
    logic [1:0] cfg_sel;
    logic [AW-1:0] cfg_addr;
    logic [NUM_IN-1:0] cfg_data;
    logic cfg_ready;
    logic in_valid;
    logic in_ready;
    logic [NUM_IN-1:0] x;
    logic out_valid;
    logic out_ready;
    logic [NUM_OUT-1:0] y;
    logic [15:0] out_cnt;
    modport master (
        output cfg_we, cfg_sel, cfg_addr, cfg_data, in_valid, x, out_ready,
        input cfg_ready, in_ready, out_valid, y, out_cnt
    );
    modport slave (
        input cfg_we, cfg_sel, cfg_addr, cfg_data, in_valid, x, out_ready,
        output cfg_ready, in_ready, out_valid, y, out_cnt
    );
endinterface

// File: rtl/aqfp_pla_pipe.sv
// aqfp_pla_pipe: two-stage pipelined PLA with run-time programmable AND/OR planes and output inversion
module aqfp_pla_pipe #(
    parameter int NUM_IN = 26,
    parameter int NUM_OUT = 10,
    parameter int NUM_TERMS = 32,
    parameter int AW = $clog2(NUM_TERMS)
) (
    input logic clk,
    input logic rst_n,
    aqfp_pla_pipe_if.slave bus
);
    logic [NUM_IN-1:0] care [NUM_TERMS];
    logic [NUM_IN-1:0] pol [NUM_TERMS];
    logic [NUM_OUT-1:0] or_mask [NUM_TERMS];
    logic [NUM_OUT-1:0] inv;
    logic [NUM_TERMS-1:0] term, s1_term;
    logic [NUM_OUT-1:0] y_next, y_r;
    logic s1_v, s2_v, adv1, adv2, cfg_wr, in_acc;
    logic [15:0] cnt;
    assign adv2 = ~s2_v | bus.out_ready;
    assign adv1 = ~s1_v | adv2;
    assign bus.cfg_ready = ~s1_v & ~s2_v;
    assign cfg_wr = bus.cfg_we & bus.cfg_ready;
    assign bus.in_ready = adv1 & ~cfg_wr;
    assign in_acc = bus.in_valid & bus.in_ready;
    assign bus.out_valid = s2_v;
    assign bus.y = y_r;
    assign bus.out_cnt = cnt;
    always_comb begin
        term = '0;
        y_next = '0;
        for (int t = 0; t < NUM_TERMS; t++) begin
            term[t] = &(~care[t] | (bus.x ~^ pol[t]));
            y_next = y_next | (or_mask[t] & {NUM_OUT{s1_term[t]}});
        end
        y_next = y_next ^ inv;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TERMS; t++) begin
                care[t] <= '0;
                pol[t] <= '0;
                or_mask[t] <= '0;
            end
            inv <= '0;
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_term <= '0;
            y_r <= '0;
            cnt <= '0;
        end else begin
            // addresses past the last term match no index and are silently dropped
            if (cfg_wr) begin
                for (int t = 0; t < NUM_TERMS; t++) begin
                    if (bus.cfg_addr == AW'(t)) begin
                        if (bus.cfg_sel == 2'd0) care[t] <= bus.cfg_data;
                        if (bus.cfg_sel == 2'd1) pol[t] <= bus.cfg_data;
                        if (bus.cfg_sel == 2'd2) or_mask[t] <= bus.cfg_data[NUM_OUT-1:0];
                    end
                end
                if (bus.cfg_sel == 2'd3) inv <= bus.cfg_data[NUM_OUT-1:0];
            end
            if (adv1) begin
                s1_v <= in_acc;
                if (in_acc) s1_term <= term;
            end
            if (adv2) begin
                s2_v <= s1_v;
                if (s1_v) y_r <= y_next;
            end
            if (s2_v & bus.out_ready) cnt <= cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_aqfp_pla_pipe.sv
// tb_aqfp_pla_pipe: table vectors plus scoreboard for the pipelined PLA
module tb_aqfp_pla_pipe;
    localparam int NI = 26;
    localparam int NO = 10;
    localparam int NT = 32;
    localparam int AW = 5;
    typedef struct { logic [NI-1:0] x; logic [NO-1:0] y; } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int popped = 0;
    logic [NO-1:0] sb [$];
    logic [NI-1:0] m_care [NT];
    logic [NI-1:0] m_pol [NT];
    logic [NO-1:0] m_or [NT];
    logic [NO-1:0] m_inv;
    logic prev_stall = 1'b0;
    logic [NO-1:0] prev_y = '0;
    aqfp_pla_pipe_if #(.NUM_IN(NI), .NUM_OUT(NO), .AW(AW)) bus ();
    aqfp_pla_pipe #(.NUM_IN(NI), .NUM_OUT(NO), .NUM_TERMS(NT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [NO-1:0] model_y(input logic [NI-1:0] xv);
        logic [NO-1:0] r = '0;
        for (int t = 0; t < NT; t++)
            if ((m_care[t] & (xv ^ m_pol[t])) == '0) r = r | m_or[t];
        return r ^ m_inv;
    endfunction
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_stall = 1'b0;
            m_inv = '0;
            for (int t = 0; t < NT; t++) begin
                m_care[t] = '0;
                m_pol[t] = '0;
                m_or[t] = '0;
            end
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_y", 32'(bus.y), 32'(prev_y));
            end
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("sb_y", 32'(bus.y), 32'(sb.pop_front()));
                popped++;
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(model_y(bus.x));
            if (bus.cfg_we && bus.cfg_ready) begin
                case (bus.cfg_sel)
                    2'd0: m_care[bus.cfg_addr] = bus.cfg_data;
                    2'd1: m_pol[bus.cfg_addr] = bus.cfg_data;
                    2'd2: m_or[bus.cfg_addr] = bus.cfg_data[NO-1:0];
                    default: m_inv = bus.cfg_data[NO-1:0];
                endcase
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_y = bus.y;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [NI-1:0] v);
        logic acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.x = v;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        check("send_accepted", 32'(acc), 32'd1);
    endtask
    task automatic cfg(input logic [1:0] sel, input logic [AW-1:0] a, input logic [NI-1:0] d);
        logic acc = 1'b0;
        bus.cfg_we = 1'b1;
        bus.cfg_sel = sel;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = bus.cfg_ready;
            tick();
        end
        bus.cfg_we = 1'b0;
        check("cfg_accepted", 32'(acc), 32'd1);
    endtask
    task automatic wait_out(output int n, output logic [NO-1:0] yv);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        yv = bus.y;
        tick();
    endtask
    task automatic drain();
        for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
        check("drained", 32'(sb.size()), 32'd0);
    endtask
    initial begin
        vec_t vt [8];
        int n;
        int sent;
        int p0;
        logic [NO-1:0] yv;
        logic acc;
        logic saw_stall;
        logic [15:0] cnt0;
        vt[0] = '{26'h0000001, 10'h001};
        vt[1] = '{26'h0000003, 10'h000};
        vt[2] = '{26'h0000000, 10'h000};
        vt[3] = '{26'h3FFFFFD, 10'h001};
        vt[4] = '{26'h2000000, 10'h302};
        vt[5] = '{26'h2000001, 10'h303};
        vt[6] = '{26'h0000000, 10'h002};
        vt[7] = '{26'h0000001, 10'h003};
        bus.cfg_we = 1'b0;
        bus.cfg_sel = 2'd0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_y", 32'(bus.y), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        check("rst_out_cnt", 32'(bus.out_cnt), 32'd0);
        tick();
        send(26'h2AAAAAA);
        wait_out(n, yv);
        check("rst_latency", 32'(n), 32'd2);
        check("rst_eval_y", 32'(yv), 32'd0);
        cfg(2'd0, 5'd0, 26'h3);
        cfg(2'd1, 5'd0, 26'h1);
        cfg(2'd2, 5'd0, 26'h001);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                cfg(2'd3, 5'd0, 26'h002);
                cfg(2'd2, 5'd5, 26'h300);
                cfg(2'd0, 5'd5, 26'h2000000);
                cfg(2'd1, 5'd5, 26'h2000000);
            end
            send(vt[i].x);
            wait_out(n, yv);
            check($sformatf("vec%0d_latency", i), 32'(n), 32'd2);
            check($sformatf("vec%0d_y", i), 32'(yv), 32'(vt[i].y));
        end
        for (int t = 0; t < 6; t++) begin
            cfg(2'd0, AW'(8 + t), NI'(4 << t));
            cfg(2'd1, AW'(8 + t), NI'(4 << t));
            cfg(2'd2, AW'(8 + t), NI'(4 << t));
        end
        cnt0 = bus.out_cnt;
        p0 = popped;
        sent = 0;
        saw_stall = 1'b0;
        for (int c = 0; c < 60 && (sent < 8 || sb.size() != 0); c++) begin
            bus.out_ready = !(c >= 3 && c <= 6);
            bus.in_valid = sent < 8;
            bus.x = NI'((sent << 2) | ((sent & 1) << 25));
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (bus.in_valid && !bus.in_ready) saw_stall = 1'b1;
            tick();
            if (acc) sent++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_sent", 32'(sent), 32'd8);
        check("bp_delivered", 32'(popped - p0), 32'd8);
        check("bp_out_cnt", 32'(16'(bus.out_cnt - cnt0)), 32'd8);
        check("bp_in_ready_stall", 32'(saw_stall), 32'd1);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);
        send(26'h0);
        bus.cfg_we = 1'b1;
        bus.cfg_sel = 2'd3;
        bus.cfg_addr = '0;
        bus.cfg_data = 26'h3FF;
        @(negedge clk);
        check("cfg_ready_busy", 32'(bus.cfg_ready), 32'd0);
        tick();
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            acc = bus.cfg_ready;
            tick();
        end
        check("cfg_after_drain", 32'(acc), 32'd1);
        bus.cfg_data = 26'h001;
        bus.in_valid = 1'b1;
        bus.x = 26'h0;
        @(negedge clk);
        check("collide_in_ready", 32'(bus.in_ready), 32'd0);
        check("collide_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        tick();
        bus.cfg_we = 1'b0;
        send(26'h0);
        wait_out(n, yv);
        check("collide_new_cfg_y", 32'(yv), 32'h001);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.x = 26'h1555555;
        sent = 0;
        for (int c = 0; c < 70000 && sent < 65534; c++) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            if (acc) sent++;
        end
        bus.in_valid = 1'b0;
        drain();
        check("wrap_preload", 32'(bus.out_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) send(NI'(i));
        drain();
        check("wrap_cnt", 32'(bus.out_cnt), 32'h0001);
        bus.out_ready = 1'b0;
        send(26'h2000000);
        send(26'h0000001);
        @(negedge clk);
        check("full_out_valid", 32'(bus.out_valid), 32'd1);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_y", 32'(bus.y), 32'd0);
        check("midrst_out_cnt", 32'(bus.out_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(bus.out_valid), 32'd0);
            tick();
        end
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
